exp_sequencer: RTL and testbench

Square-and-multiply exponentiation controller computing `base_i ** exp_i mod 2^DATA_LENGTH`. It is the initiator side of the start/done multiplier handshake: it drives operand pairs and a start pulse into an external sequential multiplier, then waits for that multiplier's done. It sits above the multiplier in the datapath and is the block that issues its requests.

---
 rtl/exp_sequencer.sv | 161 ++++++++++++++++
 tb/tb_exp_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/exp_sequencer.sv
// Square-and-multiply exponentiation controller (base ** exp mod 2^DATA_LENGTH).
// Issues operand pairs to an external start/done multiplier and walks the exponent MSB-first.
module exp_sequencer #(
    parameter int KEY_LENGTH  = 8,
    parameter int DATA_LENGTH = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [DATA_LENGTH-1:0] base_i,
    input  logic [KEY_LENGTH-1:0]  exp_i,
    output logic                   mult_start_o,
    output logic [DATA_LENGTH-1:0] mult_a_o,
    output logic [DATA_LENGTH-1:0] mult_b_o,
    input  logic [DATA_LENGTH-1:0] mult_result_i,
    input  logic                   mult_done_i,
    output logic [DATA_LENGTH-1:0] result_o,
    output logic                   done_o,
    output logic                   busy_o,
    output logic                   error_o
);

    localparam int IW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SQ_REQ, S_SQ_WAIT, S_MUL_REQ, S_MUL_WAIT, S_DONE
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [DATA_LENGTH-1:0] r_base, r_acc, r_mult_a, r_mult_b, r_result;
    logic [KEY_LENGTH-1:0]  r_exp;
    logic [IW-1:0]          r_idx;
    logic [CW-1:0]          r_wcnt;
    logic                   r_mult_start, r_done, r_busy, r_error;

    logic                   w_in_wait, w_bit, w_idx_zero, w_tmo;
    logic [CW-1:0]          w_wcnt_inc, w_wcnt_nxt;
    logic [DATA_LENGTH-1:0] w_acc_nxt, w_mult_a_nxt, w_mult_b_nxt;
    logic [IW-1:0]          w_idx_nxt;
    logic                   w_err_nxt;

    assign w_in_wait  = (r_state == S_SQ_WAIT) || (r_state == S_MUL_WAIT);
    assign w_bit      = r_exp[r_idx];
    assign w_idx_zero = (r_idx == '0);
    assign w_wcnt_inc = r_wcnt + CW'(1);
    // Timeout fires on the wait cycle whose miss would bring the count to TIMEOUT.
    assign w_tmo      = w_in_wait && !mult_done_i && (w_wcnt_inc == CW'(TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start_i) w_state_nxt = S_LOAD;
            S_LOAD:     w_state_nxt = S_SQ_REQ;
            S_SQ_REQ:   w_state_nxt = S_SQ_WAIT;
            S_SQ_WAIT: begin
                if (mult_done_i) begin
                    if (w_bit)           w_state_nxt = S_MUL_REQ;
                    else if (w_idx_zero) w_state_nxt = S_DONE;
                    else                 w_state_nxt = S_SQ_REQ;
                end else if (w_tmo) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_MUL_REQ:  w_state_nxt = S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (mult_done_i)  w_state_nxt = w_idx_zero ? S_DONE : S_SQ_REQ;
                else if (w_tmo)   w_state_nxt = S_DONE;
            end
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for datapath and outputs; outputs are registered off the next state
    // so they line up with the state they belong to.
    always_comb begin
        w_acc_nxt    = r_acc;
        w_idx_nxt    = r_idx;
        w_wcnt_nxt   = r_wcnt;
        w_err_nxt    = r_error;
        w_mult_a_nxt = r_mult_a;
        w_mult_b_nxt = r_mult_b;
        case (r_state)
            S_LOAD: begin
                w_acc_nxt = DATA_LENGTH'(1);
                w_idx_nxt = IW'(KEY_LENGTH - 1);
                w_err_nxt = 1'b0;
            end
            S_SQ_REQ, S_MUL_REQ: w_wcnt_nxt = '0;
            S_SQ_WAIT, S_MUL_WAIT: begin
                if (mult_done_i) begin
                    w_acc_nxt = mult_result_i;
                    if (!w_idx_zero && !(r_state == S_SQ_WAIT && w_bit))
                        w_idx_nxt = r_idx - IW'(1);
                end else begin
                    w_wcnt_nxt = w_wcnt_inc;
                    if (w_tmo) begin
                        w_acc_nxt = '0;
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (w_state_nxt == S_SQ_REQ) begin
            w_mult_a_nxt = w_acc_nxt;
            w_mult_b_nxt = w_acc_nxt;
        end else if (w_state_nxt == S_MUL_REQ) begin
            w_mult_a_nxt = w_acc_nxt;
            w_mult_b_nxt = r_base;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_base       <= '0;
            r_exp        <= '0;
            r_acc        <= '0;
            r_idx        <= '0;
            r_wcnt       <= '0;
            r_mult_start <= 1'b0;
            r_mult_a     <= '0;
            r_mult_b     <= '0;
            r_result     <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_base <= base_i;
                r_exp  <= exp_i;
            end
            r_acc        <= w_acc_nxt;
            r_idx        <= w_idx_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_error      <= w_err_nxt;
            r_mult_a     <= w_mult_a_nxt;
            r_mult_b     <= w_mult_b_nxt;
            r_mult_start <= (w_state_nxt == S_SQ_REQ) || (w_state_nxt == S_MUL_REQ);
            r_done       <= (w_state_nxt == S_DONE);
            r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            if (w_state_nxt == S_DONE) r_result <= w_acc_nxt;
        end
    end

    assign mult_start_o = r_mult_start;
    assign mult_a_o     = r_mult_a;
    assign mult_b_o     = r_mult_b;
    assign result_o     = r_result;
    assign done_o       = r_done;
    assign busy_o       = r_busy;
    assign error_o      = r_error;

endmodule

// File: tb/tb_exp_sequencer.sv
// Directed bench for exp_sequencer with a D=3 start/done multiplier model.
module tb_exp_sequencer;
    localparam int KL = 8;
    localparam int DL = 16;
    localparam int TO = 64;
    localparam int D  = 3;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic [DL-1:0] base_i = '0;
    logic [KL-1:0] exp_i = '0;
    logic          mult_start_o;
    logic [DL-1:0] mult_a_o, mult_b_o;
    logic [DL-1:0] mult_result_i;
    logic          mult_done_i;
    logic [DL-1:0] result_o;
    logic          done_o, busy_o, error_o;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    exp_sequencer #(.KEY_LENGTH(KL), .DATA_LENGTH(DL), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .base_i(base_i), .exp_i(exp_i),
        .mult_start_o(mult_start_o), .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
        .mult_result_i(mult_result_i), .mult_done_i(mult_done_i),
        .result_o(result_o), .done_o(done_o), .busy_o(busy_o), .error_o(error_o)
    );

    // Multiplier model: done is high D cycles after the cycle carrying the start pulse.
    logic          m_act = 1'b0;
    logic [2:0]    m_cnt = '0;
    logic [DL-1:0] m_prod = '0;
    logic          m_hang = 1'b0;
    logic          spur = 1'b0;

    always @(posedge clk_i) begin
        if (reset_i) begin
            m_act <= 1'b0;
            m_cnt <= '0;
        end else if (mult_start_o) begin
            m_act  <= 1'b1;
            m_cnt  <= 3'd1;
            m_prod <= DL'(mult_a_o * mult_b_o);
        end else if (m_act) begin
            if (m_cnt == 3'(D)) begin
                m_act <= 1'b0;
                m_cnt <= '0;
            end else begin
                m_cnt <= m_cnt + 3'd1;
            end
        end
    end

    assign mult_done_i   = (m_act && (m_cnt == 3'(D)) && !m_hang) || spur;
    assign mult_result_i = m_prod;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic run(input string tag, input logic [DL-1:0] b, input logic [KL-1:0] e,
                       input int exp_cyc, input logic [DL-1:0] exp_res, input logic exp_err,
                       input int exp_pulses, input bit noise);
        int cyc;
        int pulses;
        @(negedge clk_i);
        base_i  = b;
        exp_i   = e;
        start_i = 1'b1;
        spur    = noise;            // spurious done while still in IDLE
        @(negedge clk_i);
        start_i = 1'b0;
        spur    = 1'b0;
        cyc     = 1;
        pulses  = 0;
        while (!done_o && cyc < 400) begin
            if (mult_start_o) pulses++;
            if (noise) begin
                spur    = mult_start_o;   // done during a REQ cycle
                start_i = (cyc == 5) || (cyc == 20);
            end
            @(negedge clk_i);
            cyc++;
        end
        spur    = 1'b0;
        start_i = 1'b0;
        chk({tag, ".cycle"},  cyc,     exp_cyc);
        chk({tag, ".result"}, result_o, {16'h0, exp_res});
        chk({tag, ".error"},  error_o, {31'h0, exp_err});
        chk({tag, ".pulses"}, pulses,  exp_pulses);
        @(negedge clk_i);
        chk({tag, ".after"},  {done_o, busy_o, error_o}, {2'b00, exp_err});
        chk({tag, ".held"},   result_o, {16'h0, exp_res});
    endtask

    initial begin
        int pulses;
        int guard;
        int seen;

        repeat (3) @(negedge clk_i);
        chk("rst.ctl",  {mult_start_o, done_o, busy_o, error_o}, 4'b0000);
        chk("rst.ops",  {mult_a_o, mult_b_o}, 32'h0);
        chk("rst.res",  result_o, 32'h0);
        reset_i = 1'b0;

        run("basic",  16'h0003, 8'h05, 42, 16'h00F3, 1'b0, 10, 1'b0);
        run("zeroexp", 16'h1234, 8'h00, 34, 16'h0001, 1'b0, 8,  1'b0);
        run("wrap0",  16'h0100, 8'h02, 38, 16'h0000, 1'b0, 9,  1'b0);
        run("negone", 16'hFFFF, 8'hFF, 66, 16'hFFFF, 1'b0, 16, 1'b0);

        m_hang = 1'b1;
        run("timeout", 16'h0003, 8'h05, 2 + TO + 1, 16'h0000, 1'b1, 1, 1'b0);
        m_hang = 1'b0;
        repeat (4) @(negedge clk_i);

        run("noise",  16'h0003, 8'h05, 42, 16'h00F3, 1'b0, 10, 1'b1);

        // Reset during the 4th multiply
        @(negedge clk_i);
        base_i  = 16'h0003;
        exp_i   = 8'h05;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        pulses  = 0;
        guard   = 0;
        while (pulses < 4 && guard < 200) begin
            if (mult_start_o) pulses++;
            @(negedge clk_i);
            guard++;
        end
        chk("midrst.reach", pulses, 4);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("midrst.ctl", {mult_start_o, done_o, busy_o, error_o}, 4'b0000);
        chk("midrst.ops", {mult_a_o, mult_b_o}, 32'h0);
        chk("midrst.res", result_o, 32'h0);
        reset_i = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (done_o || busy_o) seen++;
        end
        chk("midrst.quiet", seen, 0);

        run("pow2",   16'h0002, 8'h0A, 42, 16'h0400, 1'b0, 10, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
